// File: rtl/mul_pkg.sv
// Shared types and width helpers for the sequential multiplier.
// Imported by the controller and the datapath.
package mul_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } mul_state_t;

   localparam int unsigned PROD_MULT = 2;

   function automatic int prod_w(input int w);
      return PROD_MULT * w;
   endfunction

endpackage

// File: rtl/mul_seq_dp.sv
// Shift-add datapath: A/B shift registers, P accumulator,
// sign flag and the negated/registered product.
module mul_seq_dp
   import mul_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH + 2)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               step,
   input  logic               finish,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   output logic               bzero,
   output logic [2*WIDTH-1:0] product
);

   localparam int PW = prod_w(WIDTH);

   logic [PW-1:0]    a_q, a_d;
   logic [PW-1:0]    p_q, p_d;
   logic [PW-1:0]    prod_q, prod_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic             sign_q, sign_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // operand magnitudes differ from the raw inputs only in signed mode
   always_comb begin
      mag_a = (signed_mode && a_in[WIDTH-1]) ? -a_in : a_in;
      mag_b = (signed_mode && b_in[WIDTH-1]) ? -b_in : b_in;
   end

   // next state for operand load, shift-add step and product capture
   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      p_d    = p_q;
      sign_d = sign_q;
      cnt_d  = cnt_q;
      prod_d = prod_q;
      if (load) begin
         a_d    = {{WIDTH{1'b0}}, mag_a};
         b_d    = mag_b;
         p_d    = '0;
         cnt_d  = '0;
         sign_d = signed_mode & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
      end else if (step) begin
         if (b_q[0]) begin
            p_d = p_q + a_q;
         end
         a_d   = a_q << 1;
         b_d   = b_q >> 1;
         cnt_d = cnt_q + CNT_W'(1);
      end
      if (finish) begin
         prod_d = sign_q ? -p_q : p_q;
      end
   end

   // the counter bound is a backstop; B is always empty by then
   assign bzero   = (b_q == '0) || (cnt_q == CNT_W'(WIDTH));
   assign product = prod_q;

   // datapath registers with synchronous clear
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         p_q    <= '0;
         sign_q <= 1'b0;
         cnt_q  <= '0;
         prod_q <= '0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         p_q    <= p_d;
         sign_q <= sign_d;
         cnt_q  <= cnt_d;
         prod_q <= prod_d;
      end
   end

endmodule

// File: rtl/mul_seq_param.sv
// Sequential radix-2 multiplier top: controller FSM
// driving the shift-add datapath with start/busy/done.
module mul_seq_param
   import mul_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH + 2)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   mul_state_t state_q, state_d;
   logic       load, step, finish, bzero;

   // next state, datapath strobes and handshake outputs
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            busy = 1'b1;
            if (bzero) begin
               finish  = 1'b1;
               state_d = DONE;
            end else begin
               step = 1'b1;
            end
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // state register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   mul_seq_dp #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_dp (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .step        (step),
      .finish      (finish),
      .signed_mode (signed_mode),
      .a_in        (a_in),
      .b_in        (b_in),
      .bzero       (bzero),
      .product     (product)
   );

endmodule

// File: tb/tb_mul_seq_param.sv
// Bench for mul_seq_param at WIDTH 8, 16 and 5 against
// an arithmetic reference model of product and latency.
module tb_mul_seq_param;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        st[3];
   logic        sm[3];
   logic [15:0] a_s[3];
   logic [15:0] b_s[3];
   logic        busy_o[3];
   logic        done_o[3];
   logic [15:0] p8;
   logic [31:0] p16;
   logic [9:0]  p5;
   logic [31:0] prod_o[3];

   int     checks = 0;
   int     errors = 0;
   int     cyc = 0;
   bit     chk_en = 1'b0;
   bit     m_busy[3];
   int     m_end[3];
   longint exp_p[3];
   longint cur_p[3];

   mul_seq_param #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .start(st[0]), .signed_mode(sm[0]),
      .a_in(a_s[0][7:0]), .b_in(b_s[0][7:0]),
      .busy(busy_o[0]), .done(done_o[0]), .product(p8)
   );

   mul_seq_param #(.WIDTH(16)) u_w16 (
      .clk(clk), .rst(rst), .start(st[1]), .signed_mode(sm[1]),
      .a_in(a_s[1]), .b_in(b_s[1]),
      .busy(busy_o[1]), .done(done_o[1]), .product(p16)
   );

   mul_seq_param #(.WIDTH(5)) u_w5 (
      .clk(clk), .rst(rst), .start(st[2]), .signed_mode(sm[2]),
      .a_in(a_s[2][4:0]), .b_in(b_s[2][4:0]),
      .busy(busy_o[2]), .done(done_o[2]), .product(p5)
   );

   always_comb begin
      prod_o[0] = {16'b0, p8};
      prod_o[1] = p16;
      prod_o[2] = {22'b0, p5};
   end

   function automatic int wd(input int d);
      case (d)
         0: return 8;
         1: return 16;
         default: return 5;
      endcase
   endfunction

   function automatic longint sval(input logic [15:0] x, input int w, input bit s);
      longint v;
      v = longint'(x) & ((longint'(1) << w) - 1);
      if (s && v[w-1]) v = v - (longint'(1) << w);
      return v;
   endfunction

   function automatic longint ref_prod(input logic [15:0] a, input logic [15:0] b,
                                       input int w, input bit s);
      longint r;
      r = sval(a, w, s) * sval(b, w, s);
      return r & ((longint'(1) << (2 * w)) - 1);
   endfunction

   function automatic int ref_lat(input logic [15:0] b, input int w, input bit s);
      longint m;
      m = sval(b, w, s);
      if (m < 0) m = -m;
      for (int i = w - 1; i >= 0; i--) begin
         if (m[i]) return i + 3;
      end
      return 2;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // reference model: accepts a start only when idle, then the result
   // appears after the latency given by the top set bit of |b|
   always @(posedge clk) begin
      cyc++;
      for (int d = 0; d < 3; d++) begin
         if (rst) begin
            m_busy[d] = 1'b0;
            cur_p[d]  = 0;
            m_end[d]  = -10;
         end else if (m_busy[d]) begin
            if (cyc == m_end[d]) cur_p[d] = exp_p[d];
            else if (cyc == m_end[d] + 1) m_busy[d] = 1'b0;
         end else if (st[d] === 1'b1) begin
            m_busy[d] = 1'b1;
            exp_p[d]  = ref_prod(a_s[d], b_s[d], wd(d), sm[d]);
            m_end[d]  = cyc + ref_lat(b_s[d], wd(d), sm[d]) - 1;
         end
      end
   end

   // compare every DUT output against the model each cycle
   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 3; d++) begin
            check($sformatf("w%0d busy c%0d", wd(d), cyc),
                  64'(busy_o[d]), 64'(m_busy[d]));
            check($sformatf("w%0d done c%0d", wd(d), cyc),
                  64'(done_o[d]), 64'(m_busy[d] && cyc == m_end[d]));
            check($sformatf("w%0d product c%0d", wd(d), cyc),
                  64'(prod_o[d]), 64'(cur_p[d][31:0]));
         end
      end
   end

   task automatic run_op(input bit s, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] expp, input int explat, input string nm);
      int guard;
      int lat;
      guard = 0;
      @(negedge clk);
      while (busy_o[0] !== 1'b0 && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      check({nm, " idle"}, 64'(guard < 40), 64'd1);
      st[0]  = 1'b1;
      sm[0]  = s;
      a_s[0] = {8'h00, a};
      b_s[0] = {8'h00, b};
      @(negedge clk);
      st[0] = 1'b0;
      lat = 1;
      while (done_o[0] !== 1'b1 && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      check({nm, " latency"}, 64'(lat), 64'(explat));
      check({nm, " product"}, 64'(p8), 64'(expp));
   endtask

   function automatic logic [15:0] pick(input int w, input bit sh);
      logic [15:0] mask;
      int          r;
      int          amt;
      mask = 16'((32'h1 << w) - 1);
      r    = int'($urandom_range(7, 0));
      amt  = sh ? int'($urandom_range(w - 1, 0)) : 0;
      case (r)
         0: return 16'h0;
         1: return mask;
         2: return 16'(32'h1 << (w - 1));
         default: return (16'($urandom) & mask) >> amt;
      endcase
   endfunction

   task automatic rnd_drive(input int d, input int n);
      repeat (n) begin
         @(negedge clk);
         st[d]  = ($urandom_range(3, 0) != 0);
         sm[d]  = 1'($urandom);
         a_s[d] = pick(wd(d), 1'b0);
         b_s[d] = pick(wd(d), 1'b1);
      end
      @(negedge clk);
      st[d] = 1'b0;
   endtask

   initial begin
      int dn;
      for (int d = 0; d < 3; d++) begin
         st[d]  = 1'b0;
         sm[d]  = 1'b0;
         a_s[d] = '0;
         b_s[d] = '0;
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("reset busy", 64'(busy_o[0]), 64'd0);
      check("reset done", 64'(done_o[0]), 64'd0);
      check("reset product", 64'(p8), 64'd0);
      rst = 1'b0;

      run_op(1'b0, 8'd13, 8'd11, 16'd143, 6, "u13x11");
      run_op(1'b1, 8'hFD, 8'h05, 16'hFFF1, 5, "s-3x5");
      run_op(1'b1, 8'h80, 8'h80, 16'h4000, 10, "s-128x-128");
      run_op(1'b0, 8'hFF, 8'hFF, 16'hFE01, 10, "u255x255");
      run_op(1'b0, 8'd7, 8'd0, 16'd0, 2, "u7x0");
      run_op(1'b0, 8'd0, 8'd200, 16'd0, 10, "u0x200");

      // start held high with operands changing every cycle
      @(negedge clk);
      st[0] = 1'b1;
      repeat (80) begin
         a_s[0] = 16'($urandom);
         b_s[0] = 16'($urandom);
         sm[0]  = 1'($urandom);
         @(negedge clk);
      end
      st[0] = 1'b0;

      // reset three cycles into a long operation
      run_op(1'b0, 8'd9, 8'd9, 16'd81, 6, "u9x9");
      @(negedge clk);
      st[0]  = 1'b1;
      sm[0]  = 1'b0;
      a_s[0] = 16'h00FF;
      b_s[0] = 16'h00FF;
      @(negedge clk);
      st[0] = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort busy", 64'(busy_o[0]), 64'd0);
      check("abort done", 64'(done_o[0]), 64'd0);
      check("abort product", 64'(p8), 64'd0);
      dn = 0;
      repeat (15) begin
         @(negedge clk);
         if (done_o[0] === 1'b1) dn++;
      end
      check("abort no done", 64'(dn), 64'd0);
      run_op(1'b0, 8'd2, 8'd3, 16'd6, 4, "u2x3");

      fork
         rnd_drive(0, 40000);
         rnd_drive(1, 40000);
         rnd_drive(2, 40000);
      join
      repeat (25) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
